// File: rtl/tcdm_resp_bank_if.sv
// TCDM request/response bundle for MP ports; the bank attaches as slave,
// requesters (or a bench) as master.
interface tcdm_resp_bank_if #(
  parameter int MP = 2
);
  logic [MP-1:0]       tcdm_req_i;
  logic [MP-1:0]       tcdm_gnt_o;
  logic [MP-1:0][31:0] tcdm_add_i;
  logic [MP-1:0]       tcdm_wen_i;
  logic [MP-1:0][3:0]  tcdm_be_i;
  logic [MP-1:0][31:0] tcdm_data_i;
  logic [MP-1:0][31:0] tcdm_r_data_o;
  logic [MP-1:0]       tcdm_r_valid_o;

  modport master (
    output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
    input  tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );

  modport slave (
    input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
    output tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );
endinterface

// File: rtl/tcdm_resp_bank.sv
// Single-bank TCDM memory model: round-robin grant over MP ports, optional
// periodic stall, one-cycle response latency, access counters and range flag.
module tcdm_resp_bank #(
  parameter int          MP          = 2,
  parameter int          N_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          STALL_EVERY = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tcdm_resp_bank_if.slave        tcdm,
  output logic [31:0]            n_reads_o,
  output logic [31:0]            n_writes_o,
  output logic                   addr_err_o
);

  localparam int PW  = (MP > 1) ? $clog2(MP) : 1;
  localparam int SCW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
  localparam int AW  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic [PW-1:0]       rr_ptr;
  logic [SCW-1:0]      stall_cnt;
  logic                stall;

  logic [MP-1:0]       gnt;
  logic [PW-1:0]       g_port;
  logic                g_any;

  logic [31:0]         sel_add;
  logic                sel_wen;
  logic [3:0]          sel_be;
  logic [31:0]         sel_data;
  logic [31:0]         word_off;
  logic [AW-1:0]       word_idx;
  logic                in_range;

  logic [31:0]         mem [N_WORDS];

  logic [MP-1:0]       r_valid;
  logic [MP-1:0][31:0] r_data;

  // Last counter value of each period is the stall cycle.
  assign stall = (STALL_EVERY != 0) && (stall_cnt == SCW'(STALL_EVERY - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || stall || (STALL_EVERY == 0)) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + SCW'(1);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping MP-1 -> 0.
  always_comb begin
    int idx;
    gnt    = '0;
    g_port = '0;
    g_any  = 1'b0;
    idx    = 0;
    if (!rst_i && !stall) begin
      for (int i = 0; i < MP; i++) begin
        idx = (int'(rr_ptr) + i) % MP;
        if (!g_any && tcdm.tcdm_req_i[idx]) begin
          g_any  = 1'b1;
          g_port = PW'(idx);
        end
      end
      if (g_any) begin
        gnt[g_port] = 1'b1;
      end
    end
  end

  assign tcdm.tcdm_gnt_o = gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (g_any) begin
      rr_ptr <= (g_port == PW'(MP - 1)) ? '0 : g_port + PW'(1);
    end
  end

  assign sel_add  = tcdm.tcdm_add_i[g_port];
  assign sel_wen  = tcdm.tcdm_wen_i[g_port];
  assign sel_be   = tcdm.tcdm_be_i[g_port];
  assign sel_data = tcdm.tcdm_data_i[g_port];

  // The subtraction wraps below BASE_ADDR, so the lower bound is checked on add itself.
  assign word_off = (sel_add - BASE_ADDR) >> 2;
  assign word_idx = word_off[AW-1:0];
  assign in_range = (sel_add >= BASE_ADDR) && (word_off < 32'(N_WORDS));

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (g_any && !sel_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) begin
          mem[word_idx][8*b +: 8] <= sel_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= '0;
      r_data     <= '0;
      n_reads_o  <= '0;
      n_writes_o <= '0;
      addr_err_o <= 1'b0;
    end else begin
      r_valid <= gnt;
      r_data  <= '0;
      if (g_any) begin
        if (sel_wen) begin
          r_data[g_port] <= in_range ? mem[word_idx] : 32'hDEAD_BEEF;
          if (n_reads_o != 32'hFFFF_FFFF) begin
            n_reads_o <= n_reads_o + 32'd1;
          end
        end else if (n_writes_o != 32'hFFFF_FFFF) begin
          n_writes_o <= n_writes_o + 32'd1;
        end
        if (!in_range) begin
          addr_err_o <= 1'b1;
        end
      end
    end
  end

  // A response still in flight when reset arrives is dropped, not presented.
  assign tcdm.tcdm_r_valid_o = rst_i ? '0 : r_valid;
  assign tcdm.tcdm_r_data_o  = rst_i ? '0 : r_data;

endmodule
